i2c_codec_target: RTL and testbench
===================================

# i2c_codec_target

I2C target (responder) that models the write-only control port of the audio codec, the far end of the codec configuration bus. It oversamples the open-drain SCL/SDA lines on the system clock and detects START and STOP conditions. It acknowledges 3-byte write frames (device address, then 7-bit register address plus 9-bit data) and presents each decoded register write as a one-cycle pulse. It is used in the bench as the codec model and on-chip as a configuration snoop/shadow-register source.

## Interface
Parameters:
- DEV_ADDR, 7'h1A: 7-bit device address that is acknowledged (write byte 0x34).
- NUM_REGS, 16: register addresses at or above this value are acknowledged but not written.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_sclk  in  1  raw SCL level.
- i_sdat  in  1  raw SDA level (bus value).
- o_sdat_oe  out  1  1 = pull SDA low; top level drives `sdat = oe ? 0 : z`.
- o_busy  out  1  high between a START and the following STOP.
- o_wr_valid  out  1  one-cycle pulse when a register write is decoded.
- o_wr_addr  out  7  register address; held until the next write.
- o_wr_data  out  9  register data; held until the next write.
- o_wr_ignored  out  1  one-cycle pulse when a completed write targets an address ≥ NUM_REGS.

## Operation
- SCL and SDA each pass through a 2-flop synchronizer. Synchronizer flops reset to 1, so the bus reads idle and no edge is produced at reset release.
- SCL edge events:
  - scl_rise: previous synced SCL 0, current 1.
  - scl_fall: previous 1, current 0.
- START and STOP are detected only when synced SCL is 1 in both the current and the previous sample.
  - START: SDA falls under that condition.
  - STOP: SDA rises under that condition.
  - An SDA change in the same sample as an SCL fall is ordinary data.
- Data bits are sampled MSB-first on scl_rise into an 8-bit shift register. A 3-bit counter tracks the bit position.
- FSM states: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
  - IDLE: START → ADDR.
  - ADDR: on the 8th scl_rise, byte[7:1]==DEV_ADDR and byte[0]==0 → ACK_A; otherwise → IGNORE (NACK, oe stays 0).
  - ACK_A: next scl_fall sets oe=1; the following scl_fall clears oe → BYTE1.
  - BYTE1: 8 bits latched as {reg_addr[6:0], data[8]} → ACK_1. ACK_1 behaves like ACK_A → BYTE2.
  - BYTE2: 8 bits latched as data[7:0]. On the 8th scl_rise the write is committed:
    - addr < NUM_REGS: pulse o_wr_valid and update o_wr_addr/o_wr_data.
    - otherwise: pulse o_wr_ignored only.
    - Then → ACK_2.
  - ACK_2: acknowledge like ACK_A → IGNORE. Further bytes in the frame are NACKed.
  - IGNORE: waits for STOP or START.
- Any state: START → ADDR (repeated start; partial frame discarded, oe cleared). STOP → IDLE (oe cleared, no commit).
- o_busy = (state != IDLE).

## Timing
- Reset: every output is 0, FSM is in IDLE, counters and shift register are 0. Reset asserted mid-frame drops oe in the same instant (asynchronous).
- SCL high and low phases must each be ≥ 4 i_clk cycles. Faster buses are out of scope.
- Latency from a raw SCL rise to o_wr_valid is 3 i_clk cycles (2 synchronizer cycles + 1 registered output).
- o_sdat_oe changes 3 cycles after the raw SCL fall that triggers it. The master samples ACK on SCL high, so the ACK is stable well before then.
- o_wr_valid and o_wr_ignored are exactly 1 cycle wide and never assert in the same cycle.

## Structure
- Shared package i2c_pkg holds:
  - the state enum,
  - the DEV_ADDR default,
  - the frame byte count (3).
- One sub-module, i2c_line_sync, contains:
  - the 2-flop synchronizers for both lines,
  - the scl_rise/scl_fall/start/stop pulse generation.
- The FSM, shift register and output registers live in the top module.

## Test plan
- **Valid write:** reset, then frame 0x34, 0x04, 0x79, then STOP.
  - Required: three ACKs (oe=1 across each 9th clock), one o_wr_valid with addr=2 and data=0x079, o_busy low after STOP.
- **Wrong address:** frame 0x36, 0x04, 0x79.
  - Required: oe stays 0 for the whole frame, no o_wr_valid, state IGNORE until STOP.
- **Read request:** address byte 0x35.
  - Required: NACK, no writes.
- **Out-of-range register:** 0x34, 0x1E, 0x00 (reg 15, NUM_REGS=8).
  - Required: ACKs given, o_wr_ignored pulses once, o_wr_valid stays 0.
- **Interrupted frames:**
  - Repeated START after byte 1, then a full frame 0x34, 0x00, 0x97: exactly one write, addr=0, data=0x097.
  - STOP after 4 bits of byte 2: no write, o_busy=0.
- **Reset and edge cases:**
  - Drive 0x34, 0x10, 0x01 with every SDA change coincident with the SCL fall: no spurious START/STOP, addr=8, data=0x001.
  - Assert i_rst_n low while oe=1: oe=0 immediately, and the next full frame is accepted.

Source files
------------

// File: rtl/i2c_pkg.sv
// ============================================================================
// i2c_pkg : shared types and constants for the I2C codec-port target
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_ACK_A  = 3'd2,
    ST_BYTE1  = 3'd3,
    ST_ACK_1  = 3'd4,
    ST_BYTE2  = 3'd5,
    ST_ACK_2  = 3'd6,
    ST_IGNORE = 3'd7
  } state_e;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;
  localparam int         FRAME_BYTES      = 3;

endpackage

`default_nettype wire

// File: rtl/i2c_line_sync.sv
// ============================================================================
// i2c_line_sync : 2-flop synchronizers for SCL/SDA plus edge/START/STOP pulses
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module i2c_line_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_sdat,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;
  logic scl_high_w;

  // Reset to 1 so the bus reads idle and no edge appears on reset release
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= i_sclk;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= i_sdat;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  // SDA changes only count as START/STOP when SCL is high in both samples
  assign scl_high_w = scl_prev_q & scl_s2_q;

  assign o_sda      = sda_s2_q;
  assign o_scl_rise = ~scl_prev_q & scl_s2_q;
  assign o_scl_fall = scl_prev_q & ~scl_s2_q;
  assign o_start    = scl_high_w & sda_prev_q & ~sda_s2_q;
  assign o_stop     = scl_high_w & ~sda_prev_q & sda_s2_q;

endmodule

`default_nettype wire

// File: rtl/i2c_codec_target.sv
// ============================================================================
// i2c_codec_target : write-only I2C target decoding 3-byte codec register writes
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module i2c_codec_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         NUM_REGS = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sclk,
  input  logic       i_sdat,
  output logic       o_sdat_oe,
  output logic       o_busy,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  output logic       o_wr_ignored
);

  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_line_sync u_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_sclk     (i_sclk),
    .i_sdat     (i_sdat),
    .o_sda      (sda),
    .o_scl_rise (scl_rise),
    .o_scl_fall (scl_fall),
    .o_start    (start),
    .o_stop     (stop)
  );

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       oe_q, oe_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic       data8_q, data8_d;
  logic       wr_valid_q, wr_valid_d;
  logic       wr_ignored_q, wr_ignored_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [8:0] wr_data_q, wr_data_d;

  logic [7:0] byte_w;
  logic       last_bit_w;

  assign byte_w     = {shift_q[6:0], sda};
  assign last_bit_w = (cnt_q == 3'd7);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= 8'd0;
      cnt_q        <= 3'd0;
      oe_q         <= 1'b0;
      reg_addr_q   <= 7'd0;
      data8_q      <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_ignored_q <= 1'b0;
      wr_addr_q    <= 7'd0;
      wr_data_q    <= 9'd0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      oe_q         <= oe_d;
      reg_addr_q   <= reg_addr_d;
      data8_q      <= data8_d;
      wr_valid_q   <= wr_valid_d;
      wr_ignored_q <= wr_ignored_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    oe_d         = oe_q;
    reg_addr_d   = reg_addr_q;
    data8_d      = data8_q;
    wr_valid_d   = 1'b0;
    wr_ignored_d = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    if (start) begin
      state_d = ST_ADDR;
      oe_d    = 1'b0;
      cnt_d   = 3'd0;
      shift_d = 8'd0;
    end else if (stop) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_BYTE1, ST_BYTE2: begin
          if (scl_rise) begin
            shift_d = byte_w;
            cnt_d   = cnt_q + 3'd1;
            if (last_bit_w) begin
              unique case (state_q)
                ST_ADDR: begin
                  if (byte_w[7:1] == DEV_ADDR && !byte_w[0]) state_d = ST_ACK_A;
                  else                                        state_d = ST_IGNORE;
                end
                ST_BYTE1: begin
                  reg_addr_d = byte_w[7:1];
                  data8_d    = byte_w[0];
                  state_d    = ST_ACK_1;
                end
                default: begin
                  if ({1'b0, reg_addr_q} < NUM_REGS_W) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = reg_addr_q;
                    wr_data_d  = {data8_q, byte_w};
                  end else begin
                    wr_ignored_d = 1'b1;
                  end
                  state_d = ST_ACK_2;
                end
              endcase
            end
          end
        end
        // First SCL fall drives the ACK, the second releases it and moves on
        ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = 3'd0;
              unique case (state_q)
                ST_ACK_A: state_d = ST_BYTE1;
                ST_ACK_1: state_d = ST_BYTE2;
                default:  state_d = ST_IGNORE;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sdat_oe    = oe_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_wr_valid   = wr_valid_q;
  assign o_wr_ignored = wr_ignored_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_codec_target.sv
// ============================================================================
// tb_i2c_codec_target : directed I2C master driving two targets (NUM_REGS 8/16)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_i2c_codec_target;
  import i2c_pkg::*;

  typedef struct {
    bit         ign;
    logic [6:0] addr;
    logic [8:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  wire  sda_bus;

  logic       oe8, busy8, v8, ig8;
  logic [6:0] a8;
  logic [8:0] d8;
  logic       oe16, busy16, v16, ig16;
  logic [6:0] a16;
  logic [8:0] d16;

  int vectors = 0;
  int miscompares = 0;
  exp_t q8[$];
  exp_t q16[$];

  assign sda_bus = m_sda & ~oe8 & ~oe16;

  always #5 clk = ~clk;

  i2c_codec_target #(.NUM_REGS(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(m_scl), .i_sdat(sda_bus),
    .o_sdat_oe(oe8), .o_busy(busy8), .o_wr_valid(v8), .o_wr_addr(a8),
    .o_wr_data(d8), .o_wr_ignored(ig8)
  );

  i2c_codec_target dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(m_scl), .i_sdat(sda_bus),
    .o_sdat_oe(oe16), .o_busy(busy16), .o_wr_valid(v16), .o_wr_addr(a16),
    .o_wr_data(d16), .o_wr_ignored(ig16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: every write/ignore pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && (v8 || ig8)) begin
      vectors++;
      assert (q8.size() != 0 && !(v8 && ig8) && q8[0].ign == ig8 &&
              (ig8 || (a8 === q8[0].addr && d8 === q8[0].data))) else begin
        miscompares++;
        $error("FAIL wr8 observed v=%0b ig=%0b a=%0h d=%0h expected_pending=%0d", v8, ig8, a8, d8, q8.size());
      end
      if (q8.size() != 0) void'(q8.pop_front());
    end
    if (rst_n && (v16 || ig16)) begin
      vectors++;
      assert (q16.size() != 0 && !(v16 && ig16) && q16[0].ign == ig16 &&
              (ig16 || (a16 === q16[0].addr && d16 === q16[0].data))) else begin
        miscompares++;
        $error("FAIL wr16 observed v=%0b ig=%0b a=%0h d=%0h expected_pending=%0d", v16, ig16, a16, d16, q16.size());
      end
      if (q16.size() != 0) void'(q16.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit coinc, output logic oe_hi);
    if (coinc) m_sda = b;
    cyc(4);
    if (!coinc) m_sda = b;
    cyc(4);
    m_scl = 1'b1;
    cyc(4);
    oe_hi = oe8;
    cyc(4);
    m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit coinc, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) send_bit(b[i], coinc, dummy);
    send_bit(1'b1, coinc, ack);
  endtask

  task automatic start_cond();
    m_sda = 1'b1;
    cyc(4);
    m_scl = 1'b1;
    cyc(4);
    m_sda = 1'b0;
    cyc(4);
    m_scl = 1'b0;
  endtask

  task automatic stop_cond();
    m_sda = 1'b0;
    cyc(4);
    m_scl = 1'b1;
    cyc(4);
    m_sda = 1'b1;
    cyc(8);
  endtask

  task automatic frame(input string tag, input logic [23:0] bytes, input logic [2:0] exp_ack,
                       input bit coinc);
    logic ack;
    start_cond();
    for (int i = 0; i < FRAME_BYTES; i++) begin
      send_byte(bytes[23-8*i -: 8], coinc, ack);
      check($sformatf("%s_ack%0d", tag, i), 32'(ack), 32'(exp_ack[2-i]));
    end
  endtask

  task automatic drained(input string tag);
    cyc(10);
    check({tag, "_pending8"}, 32'(q8.size()), 32'd0);
    check({tag, "_pending16"}, 32'(q16.size()), 32'd0);
  endtask

  initial begin
    logic ack;
    logic dummy;
    cyc(3);
    check("rst_oe", 32'(oe8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_addr", 32'(a8), 32'd0);
    check("rst_data", 32'(d8), 32'd0);
    rst_n = 1'b1;
    cyc(5);
    check("idle_busy", 32'(busy8), 32'd0);

    // Valid write: addr 2, data 0x079
    q8.push_back('{0, 7'd2, 9'h079});
    q16.push_back('{0, 7'd2, 9'h079});
    frame("valid", 24'h340479, 3'b111, 0);
    stop_cond();
    check("valid_busy", 32'(busy8), 32'd0);
    drained("valid");
    check("valid_addr", 32'(a8), 32'd2);
    check("valid_data", 32'(d8), 32'h079);

    // Wrong device address
    frame("wrongaddr", 24'h360479, 3'b000, 0);
    check("wrongaddr_busy", 32'(busy8), 32'd1);
    check("wrongaddr_oe", 32'(oe8), 32'd0);
    stop_cond();
    check("wrongaddr_idle", 32'(busy8), 32'd0);
    drained("wrongaddr");

    // Read request
    frame("read", 24'h350479, 3'b000, 0);
    stop_cond();
    drained("read");
    check("read_hold_addr", 32'(a8), 32'd2);

    // Register 15: out of range for NUM_REGS=8, in range for 16
    q8.push_back('{1, 7'd0, 9'd0});
    q16.push_back('{0, 7'd15, 9'h000});
    frame("oor", 24'h341E00, 3'b111, 0);
    stop_cond();
    drained("oor");
    check("oor_hold_data", 32'(d8), 32'h079);

    // Repeated START after byte 1, then a full frame
    start_cond();
    send_byte(8'h34, 0, ack);
    check("rs_ack0", 32'(ack), 32'd1);
    send_byte(8'h04, 0, ack);
    check("rs_ack1", 32'(ack), 32'd1);
    q8.push_back('{0, 7'd0, 9'h097});
    q16.push_back('{0, 7'd0, 9'h097});
    frame("rs", 24'h340097, 3'b111, 0);
    stop_cond();
    drained("rs");

    // STOP after 4 bits of byte 2
    start_cond();
    send_byte(8'h34, 0, ack);
    send_byte(8'h04, 0, ack);
    for (int i = 7; i >= 4; i--) send_bit(1'(8'h79 >> i), 0, dummy);
    stop_cond();
    check("partial_busy", 32'(busy8), 32'd0);
    drained("partial");
    check("partial_hold_addr", 32'(a8), 32'd0);

    // SDA changes coincident with SCL fall: reg 8
    q8.push_back('{1, 7'd0, 9'd0});
    q16.push_back('{0, 7'd8, 9'h001});
    frame("coinc", 24'h341001, 3'b111, 1);
    stop_cond();
    drained("coinc");
    check("coinc_addr16", 32'(a16), 32'd8);
    check("coinc_data16", 32'(d16), 32'h001);

    // Asynchronous reset while the address ACK is driven
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h34 >> i), 0, dummy);
    m_sda = 1'b1;
    cyc(8);
    m_scl = 1'b1;
    cyc(4);
    check("ack_before_rst", 32'(oe8), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_oe_async", 32'(oe8), 32'd0);
    check("rst_busy_async", 32'(busy8), 32'd0);
    check("rst_addr16", 32'(a16), 32'd0);
    m_scl = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    stop_cond();
    q8.push_back('{0, 7'd2, 9'h079});
    q16.push_back('{0, 7'd2, 9'h079});
    frame("postrst", 24'h340479, 3'b111, 0);
    stop_cond();
    drained("postrst");
    check("postrst_data", 32'(d8), 32'h079);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
